// File: rtl/tag_lookup_plru_if.sv
// Request, response, fill and flush bundle between the cache control FSM and the tag lookup engine.
interface tag_lookup_plru_if #(
  parameter int s_way   = 2,
  parameter int s_index = 4,
  parameter int s_tag   = 23
) ();
  logic               req_valid;
  logic               req_ready;
  logic [s_index-1:0] req_index;
  logic [s_tag-1:0]   req_tag;
  logic               resp_valid;
  logic               resp_hit;
  logic [s_way-1:0]   resp_way;
  logic [s_way-1:0]   resp_victim;
  logic               resp_multi_hit;
  logic               fill_we;
  logic [s_index-1:0] fill_index;
  logic [s_way-1:0]   fill_way;
  logic [s_tag-1:0]   fill_tag;
  logic               flush_start;
  logic               flush_busy;

  modport master (
    output req_valid, req_index, req_tag, fill_we, fill_index, fill_way, fill_tag, flush_start,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_victim, resp_multi_hit, flush_busy
  );

  modport slave (
    input  req_valid, req_index, req_tag, fill_we, fill_index, fill_way, fill_tag, flush_start,
    output req_ready, resp_valid, resp_hit, resp_way, resp_victim, resp_multi_hit, flush_busy
  );
endinterface

// File: rtl/tag_lookup_plru.sv
// Set-associative tag store with registered lookup, tree pseudo-LRU victim selection and set-by-set flush.
// Optional multi-hit detection is enabled by defining TAG_LOOKUP_MULTIHIT_CHECK_EN.
module tag_lookup_plru #(
  parameter int s_way    = 2,
  parameter int s_offset = 5,
  parameter int s_index  = 4,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input logic              clk,
  input logic              rst,
  tag_lookup_plru_if.slave bus
);
  localparam int s_way_num = 2 ** s_way;
  localparam int s_plru    = s_way_num - 1;
  localparam int num_sets  = 2 ** s_index;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state_reg, state_next;
  logic [s_index-1:0] flush_idx_reg, flush_idx_next;

  logic [s_tag-1:0]     tag_mem   [num_sets][s_way_num];
  logic [s_way_num-1:0] valid_reg [num_sets];
  logic [s_plru-1:0]    plru_reg  [num_sets];

  logic             resp_valid_reg, resp_hit_reg;
  logic [s_way-1:0] resp_way_reg, resp_victim_reg;

  logic [s_way_num-1:0] match, invalid;
  logic [s_way-1:0]     hit_way, invalid_way, victim_way;
  logic                 hit, accept;

  // Every node on the way's path is pointed at the opposite half.
  function automatic logic [s_plru-1:0] plru_touch(input logic [s_plru-1:0] p,
                                                   input logic [s_way-1:0] w);
    logic [s_plru-1:0] r;
    int node;
    r = p;
    node = 0;
    for (int lvl = 0; lvl < s_way; lvl++) begin
      r[node] = ~w[s_way-1-lvl];
      node = w[s_way-1-lvl] ? 2 * node + 2 : 2 * node + 1;
    end
    return r;
  endfunction

  function automatic logic [s_way-1:0] plru_walk(input logic [s_plru-1:0] p);
    logic [s_way-1:0] w;
    int node;
    w = '0;
    node = 0;
    for (int lvl = 0; lvl < s_way; lvl++) begin
      w[s_way-1-lvl] = p[node];
      node = p[node] ? 2 * node + 2 : 2 * node + 1;
    end
    return w;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < s_way_num; gi++) begin : g_way
      assign match[gi]   = valid_reg[bus.req_index][gi] && (tag_mem[bus.req_index][gi] == bus.req_tag);
      assign invalid[gi] = !valid_reg[bus.req_index][gi];
    end
  endgenerate

  // Descending scans leave the lowest-numbered candidate in place.
  always_comb begin
    hit_way     = '0;
    invalid_way = '0;
    for (int w = s_way_num - 1; w >= 0; w--) begin
      if (match[w])   hit_way     = w[s_way-1:0];
      if (invalid[w]) invalid_way = w[s_way-1:0];
    end
  end

  assign hit        = |match;
  assign victim_way = (|invalid) ? invalid_way : plru_walk(plru_reg[bus.req_index]);
  assign accept     = bus.req_valid && bus.req_ready;

  assign bus.req_ready   = (state_reg == IDLE) && !bus.fill_we;
  assign bus.flush_busy  = (state_reg == FLUSH);
  assign bus.resp_valid  = resp_valid_reg;
  assign bus.resp_hit    = resp_hit_reg;
  assign bus.resp_way    = resp_way_reg;
  assign bus.resp_victim = resp_victim_reg;

  always_comb begin
    state_next     = state_reg;
    flush_idx_next = flush_idx_reg;
    case (state_reg)
      IDLE: begin
        if (bus.flush_start) begin
          state_next     = FLUSH;
          flush_idx_next = '0;
        end
      end
      FLUSH: begin
        flush_idx_next = flush_idx_reg + 1'b1;
        if (flush_idx_reg == s_index'(num_sets - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      flush_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_idx_reg <= flush_idx_next;
    end
  end

  // Fill and accepted lookup are exclusive because req_ready drops while fill_we is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < num_sets; s++) begin
        valid_reg[s] <= '0;
        plru_reg[s]  <= '0;
      end
      resp_valid_reg  <= 1'b0;
      resp_hit_reg    <= 1'b0;
      resp_way_reg    <= '0;
      resp_victim_reg <= '0;
    end else begin
      resp_valid_reg <= accept;
      if (accept) begin
        resp_hit_reg    <= hit;
        resp_way_reg    <= hit_way;
        resp_victim_reg <= victim_way;
      end
      if (state_reg == IDLE) begin
        if (bus.fill_we) begin
          valid_reg[bus.fill_index][bus.fill_way] <= 1'b1;
          plru_reg[bus.fill_index] <= plru_touch(plru_reg[bus.fill_index], bus.fill_way);
        end else if (accept && hit) begin
          plru_reg[bus.req_index] <= plru_touch(plru_reg[bus.req_index], hit_way);
        end
      end else begin
        valid_reg[flush_idx_reg] <= '0;
        plru_reg[flush_idx_reg]  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state_reg == IDLE) && bus.fill_we)
      tag_mem[bus.fill_index][bus.fill_way] <= bus.fill_tag;
  end

`ifdef TAG_LOOKUP_MULTIHIT_CHECK_EN
  logic [s_way:0] match_cnt;
  logic           resp_multi_reg;

  always_comb begin
    match_cnt = '0;
    for (int w = 0; w < s_way_num; w++) match_cnt = match_cnt + {{s_way{1'b0}}, match[w]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         resp_multi_reg <= 1'b0;
    else if (accept) resp_multi_reg <= (match_cnt > 1);
  end

  assign bus.resp_multi_hit = resp_multi_reg;
`else
  assign bus.resp_multi_hit = 1'b0;
`endif

endmodule

// File: tb/tb_tag_lookup_plru.sv
// Directed scoreboard bench for tag_lookup_plru: lookups, fills, PLRU victims, flush and reset abort.
module tb_tag_lookup_plru;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  tag_lookup_plru_if #(.s_way(2), .s_index(4), .s_tag(23)) bus ();

  tag_lookup_plru #(.s_way(2), .s_offset(5), .s_index(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef TAG_LOOKUP_MULTIHIT_CHECK_EN
  localparam logic MH = 1'b1;
`else
  localparam logic MH = 1'b0;
`endif

  typedef struct packed {
    logic       hit;
    logic [1:0] way;
    logic [1:0] victim;
    logic       multi;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  task automatic fill(input logic [3:0] idx, input logic [1:0] way, input logic [22:0] tg);
    @(negedge clk);
    bus.fill_we    = 1'b1;
    bus.fill_index = idx;
    bus.fill_way   = way;
    bus.fill_tag   = tg;
    @(posedge clk);
    #1;
    bus.fill_we = 1'b0;
    $display("fill   idx=%0d way=%0d tag=%0h", idx, way, tg);
  endtask

  task automatic lookup(input string name, input logic [3:0] idx, input logic [22:0] tg,
                        input logic eh, input logic [1:0] ew, input logic [1:0] ev,
                        input logic em, input logic with_flush);
    exp_t e;
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_index   = idx;
    bus.req_tag     = tg;
    bus.flush_start = with_flush;
    exp_q.push_back('{hit: eh, way: ew, victim: ev, multi: em});
    @(posedge clk);
    #1;
    bus.req_valid   = 1'b0;
    bus.flush_start = 1'b0;
    chk({name, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({name, ".hit"},    32'(bus.resp_hit),       32'(e.hit));
      chk({name, ".way"},    32'(bus.resp_way),       32'(e.way));
      chk({name, ".victim"}, 32'(bus.resp_victim),    32'(e.victim));
      chk({name, ".multi"},  32'(bus.resp_multi_hit), 32'(e.multi));
    end
    $display("lookup %s idx=%0d tag=%0h hit=%0b way=%0d victim=%0d multi=%0b",
             name, idx, tg, bus.resp_hit, bus.resp_way, bus.resp_victim, bus.resp_multi_hit);
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_index   = '0;
    bus.req_tag     = '0;
    bus.fill_we     = 1'b0;
    bus.fill_index  = '0;
    bus.fill_way    = '0;
    bus.fill_tag    = '0;
    bus.flush_start = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.resp_hit",   32'(bus.resp_hit),   32'd0);
    chk("rst.resp_way",   32'(bus.resp_way),   32'd0);
    chk("rst.flush_busy", 32'(bus.flush_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);

    lookup("empty", 4'd3, 23'h12345, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    // Set 5: fills 0..3 leave PLRU 000, hit way 2 then points victim back to way 0
    for (int w = 0; w < 4; w++) fill(4'd5, 2'(w), 23'(10 + w));
    lookup("s5_hit_c", 4'd5, 23'hC, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pulse.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("hold.resp_hit",    32'(bus.resp_hit),   32'd1);
    chk("hold.resp_way",    32'(bus.resp_way),   32'd2);
    lookup("s5_miss", 4'd5, 23'hE, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    // Set 1: back-to-back hits 0 then 2 steer the victim to way 1
    for (int w = 0; w < 4; w++) fill(4'd1, 2'(w), 23'(32'h100 + w));
    lookup("s1_hit0", 4'd1, 23'h100, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    lookup("s1_hit2", 4'd1, 23'h102, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0);
    lookup("s1_miss", 4'd1, 23'h1FF, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0);

    // Fill has priority: request is not accepted in the same cycle
    @(negedge clk);
    bus.fill_we    = 1'b1;
    bus.fill_index = 4'd2;
    bus.fill_way   = 2'd0;
    bus.fill_tag   = 23'h55;
    bus.req_valid  = 1'b1;
    bus.req_index  = 4'd2;
    bus.req_tag    = 23'h55;
    #1;
    chk("fill_block.req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.fill_we   = 1'b0;
    bus.req_valid = 1'b0;
    chk("fill_block.resp_valid", 32'(bus.resp_valid), 32'd0);

    // Duplicate tag in ways 1 and 3
    fill(4'd0, 2'd1, 23'h7);
    fill(4'd0, 2'd3, 23'h7);
    lookup("multi", 4'd0, 23'h7, 1'b1, 2'd1, 2'd0, MH, 1'b0);

    // Flush started together with a lookup that still sees pre-flush contents
    lookup("preflush", 4'd5, 23'hB, 1'b1, 2'd1, 2'd0, 1'b0, 1'b1);
    chk("flush.busy_0", 32'(bus.flush_busy), 32'd1);
    chk("flush.ready_0", 32'(bus.req_ready), 32'd0);
    for (int i = 1; i < 16; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("flush.busy_%0d", i), 32'(bus.flush_busy), 32'd1);
      chk($sformatf("flush.ready_%0d", i), 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("flush.busy_end",  32'(bus.flush_busy), 32'd0);
    chk("flush.ready_end", 32'(bus.req_ready),  32'd1);
    lookup("post_s5", 4'd5, 23'hC,   1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    lookup("post_s1", 4'd1, 23'h100, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    lookup("post_s0", 4'd0, 23'h7,   1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    // Reset while flushing set 7
    fill(4'd9, 2'd0, 23'h90);
    fill(4'd9, 2'd1, 23'h91);
    lookup("s9_hit1", 4'd9, 23'h91, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    bus.flush_start = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.resp_valid",  32'(bus.resp_valid),     32'd0);
    chk("midrst.resp_hit",    32'(bus.resp_hit),       32'd0);
    chk("midrst.resp_way",    32'(bus.resp_way),       32'd0);
    chk("midrst.resp_victim", 32'(bus.resp_victim),    32'd0);
    chk("midrst.multi",       32'(bus.resp_multi_hit), 32'd0);
    chk("midrst.flush_busy",  32'(bus.flush_busy),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst.req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("midrst.busy_after", 32'(bus.flush_busy), 32'd0);
    lookup("s9_after_rst", 4'd9, 23'h91, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
